// File: rtl/tmds_decoder_if.sv
// Per-channel TMDS receive bus: raw deserialized word in, decoded symbol
// and alignment status out.
interface tmds_decoder_if;
    logic [9:0] sym_in;
    logic [7:0] dout;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    modport master (output sym_in, input dout, ctrl, de, locked, offset);
    modport slave  (input sym_in, output dout, ctrl, de, locked, offset);
endinterface

// File: rtl/tmds_decoder.sv
// One TMDS channel receiver: finds the 10-bit symbol boundary from
// control-token runs, then decodes data bytes and control values.
module tmds_decoder #(
    parameter int CTRL_LOCK      = 64,
    parameter int SEARCH_TIMEOUT = 4096
) (
    input  logic          clk_pix,
    input  logic          rst_pix_n,
    tmds_decoder_if.slave tmds
);
    localparam int TW = $clog2(SEARCH_TIMEOUT);
    localparam int RW = $clog2(CTRL_LOCK + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX   = RW'(CTRL_LOCK);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [9:0]    cur_q, prev_q;
    logic [3:0]    offset_q, offset_d, offset_nxt;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic [7:0]    dout_q, dout_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          de_q, de_d;

    logic [19:0]   win;
    logic [4:0]    off_ext;
    logic [9:0]    sym;
    logic          is_tok;
    logic [1:0]    tok_val;
    logic [7:0]    dinv;
    logic [7:0]    data;

    // Two-word window so any bit phase 0..9 yields a full symbol.
    assign win     = {cur_q, prev_q};
    assign off_ext = {1'b0, offset_q};
    assign sym     = win[off_ext +: 10];

    always_comb begin
        is_tok  = 1'b1;
        tok_val = 2'b00;
        case (sym)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok  = 1'b0;
        endcase
    end

    always_comb begin
        dinv    = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = '0;
        data[0] = dinv[0];
        for (int i = 1; i < 8; i++)
            data[i] = sym[8] ? (dinv[i] ^ dinv[i-1]) : ~(dinv[i] ^ dinv[i-1]);
    end

    assign offset_nxt = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    assign run_inc    = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q  <= SEARCH;
            offset_q <= '0;
            timer_q  <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            timer_q  <= timer_d;
            run_q    <= run_d;
        end
    end

    // Lock is checked before timeout so a lock on the timeout cycle keeps the offset.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        timer_d  = timer_q + TW'(1);
        run_d    = is_tok ? run_inc : '0;
        case (state_q)
            SEARCH: begin
                if (is_tok && run_inc == RUN_MAX) begin
                    state_d = LOCKED;
                    timer_d = '0;
                end else if (timer_q == TIMER_MAX) begin
                    offset_d = offset_nxt;
                    timer_d  = '0;
                    run_d    = '0;
                end
            end
            LOCKED: begin
                if (is_tok) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_MAX) begin
                    state_d  = SEARCH;
                    offset_d = offset_nxt;
                    timer_d  = '0;
                    run_d    = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Outputs follow the next state so locked and de/dout change together.
    always_comb begin
        dout_d = '0;
        de_d   = 1'b0;
        ctrl_d = ctrl_q;
        if (state_d != LOCKED) begin
            ctrl_d = '0;
        end else if (is_tok) begin
            ctrl_d = tok_val;
        end else begin
            de_d   = 1'b1;
            dout_d = data;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cur_q  <= '0;
            prev_q <= '0;
            dout_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else begin
            cur_q  <= tmds.sym_in;
            prev_q <= cur_q;
            dout_q <= dout_d;
            ctrl_q <= ctrl_d;
            de_q   <= de_d;
        end
    end

    assign tmds.dout   = dout_q;
    assign tmds.ctrl   = ctrl_q;
    assign tmds.de     = de_q;
    assign tmds.locked = (state_q == LOCKED);
    assign tmds.offset = offset_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboarded bench for tmds_decoder: drives encoded DVI streams at chosen
// bit slips and checks decode, lock acquisition/loss and offset stepping.
module tb_tmds_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    tmds_decoder_if bus ();

    tmds_decoder u_dut (
        .clk_pix   (clk),
        .rst_pix_n (rst_n),
        .tmds      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};

    typedef struct {
        int         due;
        logic [7:0] dout;
        logic [1:0] ctrl;
        logic       de;
        logic       lk;
    } exp_t;

    exp_t       sb [$];
    int         slip = 0;
    logic [9:0] carry = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference encoder with the usual transition-minimising XOR/XNOR choice.
    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        int         n1;
        logic       use_xor;
        logic [7:0] q;
        n1      = $countones(d);
        use_xor = !(n1 > 4 || (n1 == 4 && d[0] == 1'b0));
        q       = '0;
        q[0]    = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xor ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
        return {inv, use_xor, inv ? ~q : q};
    endfunction

    // Called right after a negedge; the word is sampled at the next posedge.
    task automatic send(input logic [9:0] s, input bit ex, input logic [7:0] e_dout,
                        input logic [1:0] e_ctrl, input logic e_de, input logic e_lk);
        logic [19:0] t;
        exp_t        e;
        t = ({10'd0, s} << slip) | {10'd0, carry};
        bus.sym_in = t[9:0];
        carry      = t[19:10];
        if (ex) begin
            e.due  = cyc + 3;
            e.dout = e_dout;
            e.ctrl = e_ctrl;
            e.de   = e_de;
            e.lk   = e_lk;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic tok(input int v, input bit ex, input logic lk, input logic [1:0] c);
        send(TOK[v], ex, 8'h00, c, 1'b0, lk);
    endtask

    task automatic dat(input logic [7:0] b, input logic inv, input bit ex, input logic [1:0] c);
        send(enc(b, inv), ex, b, c, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        sb.delete();
        bus.sym_in = '0;
        slip       = 0;
        carry      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("dout",   32'(bus.dout),   32'(e.dout));
            chk("ctrl",   32'(bus.ctrl),   32'(e.ctrl));
            chk("de",     32'(bus.de),     32'(e.de));
            chk("locked", 32'(bus.locked), 32'(e.lk));
        end
    end

    initial begin
        logic [7:0] b;
        logic       iv;
        logic [7:0] bytes [10];
        bytes = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h81, 8'h00, 8'hFF};
        bus.sym_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_offset", 32'(bus.offset), 0);
        chk("rst_de",     32'(bus.de),     0);
        chk("rst_dout",   32'(bus.dout),   0);
        chk("rst_ctrl",   32'(bus.ctrl),   0);

        // Token-free search: offset steps every 4096 cycles and wraps 9 -> 0.
        do_reset();
        for (int i = 0; i < 10 * 4096; i++) begin
            send(10'd0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
            if ((i + 1) % 4096 == 0 || (i + 1) % 4096 == 4095)
                chk("offset_step", 32'(bus.offset), 32'(((i + 1) / 4096) % 10));
        end
        chk("wrap_unlocked", 32'(bus.locked), 0);

        // 64th token lands exactly on the first timeout cycle.
        do_reset();
        for (int i = 0; i < 4096; i++) begin
            send((i >= 4030) ? TOK[1] : 10'd0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
            if (i == 4094) chk("tie_prelock", 32'(bus.locked), 0);
            if (i == 4095) begin
                chk("tie_locked", 32'(bus.locked), 1);
                chk("tie_offset", 32'(bus.offset), 0);
            end
        end

        // Aligned stream: lock after 64 tokens, then 0x55.
        do_reset();
        for (int i = 0; i < 100; i++) tok(0, 1'b1, i >= 63, 2'b00);
        dat(8'h55, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) tok(0, 1'b1, 1'b1, 2'b00);

        // Each token value in turn, then data with ctrl held at 11.
        for (int v = 0; v < 4; v++)
            for (int i = 0; i < 70; i++) tok(v, 1'b1, 1'b1, 2'(v));
        for (int i = 0; i < 10; i++) dat(bytes[i], 1'(i), 1'b1, 2'b11);

        // Data-only run: lock drops on the 4096th token-free cycle.
        for (int i = 0; i < 5; i++) tok(2, 1'b1, 1'b1, 2'b10);
        for (int j = 0; j < 5000; j++) begin
            b  = 8'($urandom);
            iv = 1'($urandom_range(0, 1));
            if (j < 4095) dat(b, iv, 1'b1, 2'b10);
            else          send(enc(b, iv), 1'b1, 8'h00, 2'b00, 1'b0, 1'b0);
        end
        chk("unlock_offset", 32'(bus.offset), 1);
        chk("unlock_locked", 32'(bus.locked), 0);

        // Stream slipped by 3 bits: search walks 0..3 then locks at 3.
        do_reset();
        slip = 3;
        for (int i = 0; i < 12400; i++) begin
            tok(0, 1'b0, 1'b0, 2'b00);
            if ((i + 1) == 4095 || (i + 1) == 4096 || (i + 1) == 8191 ||
                (i + 1) == 8192 || (i + 1) == 12287 || (i + 1) == 12288)
                chk("slip_offset", 32'(bus.offset), 32'((i + 1) / 4096));
            if (i == 12350) chk("slip_prelock", 32'(bus.locked), 0);
            if (i == 12351) begin
                chk("slip_locked", 32'(bus.locked), 1);
                chk("slip_lock_off", 32'(bus.offset), 3);
            end
        end
        for (int i = 0; i < 20; i++) dat(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) tok(0, 1'b1, 1'b1, 2'b00);
        for (int i = 0; i < 6; i++) dat(8'($urandom), 1'($urandom_range(0, 1)), 1'b1, 2'b00);

        // Asynchronous reset while locked and passing data.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(bus.locked), 0);
        chk("arst_de",     32'(bus.de),     0);
        chk("arst_dout",   32'(bus.dout),   0);
        chk("arst_ctrl",   32'(bus.ctrl),   0);
        chk("arst_offset", 32'(bus.offset), 0);
        sb.delete();
        bus.sym_in = '0;
        slip       = 0;
        carry      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) tok(3, 1'b1, i >= 63, (i >= 63) ? 2'b11 : 2'b00);
        for (int i = 0; i < 4; i++) dat(8'($urandom), 1'(i), 1'b1, 2'b11);
        for (int i = 0; i < 4; i++) tok(1, 1'b1, 1'b1, 2'b01);

        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
